// File: rtl/adc_dac_beat_packer_if.sv
// adc_dac_beat_packer_if
//   Groups the input and output AXI4-Stream signals of adc_dac_beat_packer.
//   s_axis_* : NCH lock-step ADC beats, channel c at [c*IN_WIDTH +: IN_WIDTH].
//   m_axis_* : NCH packed DAC beats, lane c at [c*IN_WIDTH*RATIO +: IN_WIDTH*RATIO].
//   slave  modport : the packer's view (consumes s_axis, produces m_axis).
//   master modport : the environment's view (produces s_axis, consumes m_axis).
interface adc_dac_beat_packer_if #(
   parameter int unsigned NCH      = 2,
   parameter int unsigned IN_WIDTH = 128,
   parameter int unsigned RATIO    = 2
);
   logic [NCH*IN_WIDTH-1:0]       s_axis_tdata;
   logic                          s_axis_tvalid;
   logic                          s_axis_tready;
   logic [NCH*IN_WIDTH*RATIO-1:0] m_axis_tdata;
   logic                          m_axis_tvalid;
   logic                          m_axis_tready;

   modport slave (
      input  s_axis_tdata, s_axis_tvalid, m_axis_tready,
      output s_axis_tready, m_axis_tdata, m_axis_tvalid
   );

   modport master (
      output s_axis_tdata, s_axis_tvalid, m_axis_tready,
      input  s_axis_tready, m_axis_tdata, m_axis_tvalid
   );
endinterface

// File: rtl/adc_dac_beat_packer.sv
// adc_dac_beat_packer
//   Packs RATIO consecutive lock-step ADC beats of NCH channels into one wide beat
//   per channel. The packing phase is either free-running from reset or locked to
//   SYSREF rising edges; stalls and phase slips are reported.
// Ports:
//   aclk, aresetn  : stream clock, asynchronous active-low reset
//   sysref         : SYSREF level already registered into aclk
//   align_en       : allow SYSREF edges to (re)set the packing phase
//   axis           : s_axis/m_axis stream bundle (slave modport)
//   aligned        : packing phase is valid
//   overflow       : sticky, input valid seen while not ready
//   overflow_clr   : single-cycle clear of overflow (a same-cycle set wins)
//   realign_count  : SYSREF edges seen at a non-zero phase, saturating at 255
module adc_dac_beat_packer #(
   parameter int unsigned NCH          = 2,
   parameter int unsigned IN_WIDTH     = 128,
   parameter int unsigned RATIO        = 2,
   parameter bit          ALIGN_SYSREF = 1'b1
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic                  sysref,
   input  logic                  align_en,
   adc_dac_beat_packer_if.slave  axis,
   output logic                  aligned,
   output logic                  overflow,
   input  logic                  overflow_clr,
   output logic [7:0]            realign_count
);

   localparam int unsigned LaneW  = IN_WIDTH * RATIO;
   localparam int unsigned OutW   = NCH * LaneW;
   localparam int unsigned PhaseW = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam logic [PhaseW-1:0] LastPhase = PhaseW'(RATIO - 1);

   logic [PhaseW-1:0] phase_q, phase_d;
   logic [OutW-1:0]   asm_q, asm_d;
   logic [OutW-1:0]   out_q, out_d;
   logic              valid_q, valid_d;
   logic              aligned_q, aligned_d;
   logic              overflow_q, overflow_d;
   logic [7:0]        realign_q, realign_d;
   logic              sysref_q;

   logic              s_ready;
   logic              sysref_edge;
   logic              align_ev;
   logic              accept;
   logic              take;
   logic              complete;
   logic [PhaseW-1:0] wr_phase;

   always_comb begin
      sysref_edge = sysref & ~sysref_q;
      align_ev    = ALIGN_SYSREF && sysref_edge && align_en;

      // Only a completing beat can be blocked, and only by an unconsumed output.
      // While unaligned the beats are swallowed, so ready stays high.
      s_ready  = ~aligned_q | ~((phase_q == LastPhase) & valid_q & ~axis.m_axis_tready);
      accept   = axis.s_axis_tvalid & s_ready;
      take     = accept & (aligned_q | align_ev);
      // An alignment edge makes the same-cycle beat beat 0 of a fresh group;
      // at phase 0 this is identical to normal operation.
      wr_phase = align_ev ? '0 : phase_q;
      complete = take & (wr_phase == LastPhase);

      phase_d    = phase_q;
      asm_d      = asm_q;
      out_d      = out_q;
      valid_d    = valid_q;
      aligned_d  = aligned_q;
      overflow_d = overflow_q;
      realign_d  = realign_q;

      if (take) begin
         for (int c = 0; c < int'(NCH); c++) begin
            for (int p = 0; p < int'(RATIO); p++) begin
               if (wr_phase == PhaseW'(p)) begin
                  asm_d[c*LaneW + p*IN_WIDTH +: IN_WIDTH] =
                     axis.s_axis_tdata[c*IN_WIDTH +: IN_WIDTH];
               end
            end
         end
         phase_d = complete ? '0 : wr_phase + 1'b1;
      end else if (align_ev) begin
         phase_d = '0;
      end

      // Load straight from the merged assembly value so the group is out one
      // cycle after its last beat.
      if (complete) begin
         out_d   = asm_d;
         valid_d = 1'b1;
      end else if (valid_q & axis.m_axis_tready) begin
         valid_d = 1'b0;
      end

      if (axis.s_axis_tvalid & ~s_ready) begin
         overflow_d = 1'b1;
      end else if (overflow_clr) begin
         overflow_d = 1'b0;
      end

      if (align_ev) begin
         aligned_d = 1'b1;
         if (aligned_q && (phase_q != '0) && (realign_q != 8'hFF)) begin
            realign_d = realign_q + 8'd1;
         end
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         phase_q    <= '0;
         asm_q      <= '0;
         out_q      <= '0;
         valid_q    <= 1'b0;
         aligned_q  <= ~ALIGN_SYSREF;
         overflow_q <= 1'b0;
         realign_q  <= 8'd0;
         // High at reset so a sysref already high at release is not an edge.
         sysref_q   <= 1'b1;
      end else begin
         phase_q    <= phase_d;
         asm_q      <= asm_d;
         out_q      <= out_d;
         valid_q    <= valid_d;
         aligned_q  <= aligned_d;
         overflow_q <= overflow_d;
         realign_q  <= realign_d;
         sysref_q   <= sysref;
      end
   end

   assign axis.s_axis_tready = s_ready;
   assign axis.m_axis_tdata  = out_q;
   assign axis.m_axis_tvalid = valid_q;
   assign aligned            = aligned_q;
   assign overflow           = overflow_q;
   assign realign_count      = realign_q;

endmodule

// File: tb/tb_adc_dac_beat_packer.sv
// tb_adc_dac_beat_packer
//   Three packers share one clock and reset: a free-running RATIO=2 packer, a
//   SYSREF-aligned RATIO=4 packer and a RATIO=1 pass-through. Expected output
//   beats are queued as stimulus is driven and compared when each DUT hands over.
module tb_adc_dac_beat_packer;

   logic aclk = 1'b0;
   logic aresetn;
   logic sysref;
   logic align_en;
   logic ovf_clr;

   always #5 aclk = ~aclk;

   int n_total = 0;
   int n_bad   = 0;

   logic [1023:0] q_pk[$];
   logic [1023:0] q_al[$];
   logic [1023:0] q_pt[$];

   logic       pk_aligned, pk_overflow, al_aligned, al_overflow, pt_aligned, pt_overflow;
   logic [7:0] pk_realign, al_realign, pt_realign;

   adc_dac_beat_packer_if #(.NCH(2), .IN_WIDTH(128), .RATIO(2)) p_if ();
   adc_dac_beat_packer_if #(.NCH(2), .IN_WIDTH(128), .RATIO(4)) a_if ();
   adc_dac_beat_packer_if #(.NCH(2), .IN_WIDTH(128), .RATIO(1)) t_if ();

   adc_dac_beat_packer #(.NCH(2), .IN_WIDTH(128), .RATIO(2), .ALIGN_SYSREF(1'b0)) u_pk (
      .aclk(aclk), .aresetn(aresetn), .sysref(sysref), .align_en(align_en), .axis(p_if),
      .aligned(pk_aligned), .overflow(pk_overflow), .overflow_clr(ovf_clr),
      .realign_count(pk_realign)
   );

   adc_dac_beat_packer #(.NCH(2), .IN_WIDTH(128), .RATIO(4), .ALIGN_SYSREF(1'b1)) u_al (
      .aclk(aclk), .aresetn(aresetn), .sysref(sysref), .align_en(align_en), .axis(a_if),
      .aligned(al_aligned), .overflow(al_overflow), .overflow_clr(ovf_clr),
      .realign_count(al_realign)
   );

   adc_dac_beat_packer #(.NCH(2), .IN_WIDTH(128), .RATIO(1), .ALIGN_SYSREF(1'b0)) u_pt (
      .aclk(aclk), .aresetn(aresetn), .sysref(sysref), .align_en(align_en), .axis(t_if),
      .aligned(pt_aligned), .overflow(pt_overflow), .overflow_clr(ovf_clr),
      .realign_count(pt_realign)
   );

   task automatic check_val(input string tag, input logic [1023:0] got,
                            input logic [1023:0] exp);
      n_total++;
      if (got !== exp) begin
         int w;
         w = 0;
         n_bad++;
         for (int i = 7; i >= 0; i--) begin
            if (got[i*128 +: 128] !== exp[i*128 +: 128]) w = i;
         end
         $display("FAIL %s: word %0d got %0h want %0h", tag, w, got[w*128 +: 128],
                  exp[w*128 +: 128]);
      end
   endtask

   // Channel c of a beat carries v + c*off.
   function automatic logic [255:0] beat(input int v, input int off);
      return {128'(v + off), 128'(v)};
   endfunction

   // Packed group of beats v0..v0+ratio-1, beat k at lane offset k*128.
   function automatic logic [1023:0] grp(input int v0, input int ratio, input int off);
      logic [1023:0] r;
      r = '0;
      for (int c = 0; c < 2; c++) begin
         for (int k = 0; k < ratio; k++) begin
            r[c*ratio*128 + k*128 +: 128] = 128'(v0 + k + c*off);
         end
      end
      return r;
   endfunction

   task automatic pk_drive(input int v);
      int n;
      n = 0;
      p_if.s_axis_tdata  = beat(v, 16);
      p_if.s_axis_tvalid = 1'b1;
      @(negedge aclk);
      while (!p_if.s_axis_tready && n < 20) begin
         @(negedge aclk);
         n++;
      end
      if (n == 20) check_val("pk_drive_timeout", 1024'(p_if.s_axis_tready), 1024'(1));
      @(posedge aclk);
      #1;
   endtask

   task automatic al_drive(input int v, input logic sr);
      int n;
      n = 0;
      a_if.s_axis_tdata  = beat(v, 256);
      a_if.s_axis_tvalid = 1'b1;
      sysref             = sr;
      @(negedge aclk);
      while (!a_if.s_axis_tready && n < 20) begin
         @(negedge aclk);
         n++;
      end
      if (n == 20) check_val("al_drive_timeout", 1024'(a_if.s_axis_tready), 1024'(1));
      @(posedge aclk);
      #1;
   endtask

   always @(negedge aclk) begin
      if (aresetn && p_if.m_axis_tvalid && p_if.m_axis_tready) begin
         check_val("pk_sb_nonempty", 1024'(q_pk.size() != 0), 1024'(1));
         if (q_pk.size() != 0) check_val("pk_out", 1024'(p_if.m_axis_tdata), q_pk.pop_front());
      end
      if (aresetn && a_if.m_axis_tvalid && a_if.m_axis_tready) begin
         check_val("al_sb_nonempty", 1024'(q_al.size() != 0), 1024'(1));
         if (q_al.size() != 0) check_val("al_out", 1024'(a_if.m_axis_tdata), q_al.pop_front());
      end
      if (aresetn && t_if.m_axis_tvalid && t_if.m_axis_tready) begin
         check_val("pt_sb_nonempty", 1024'(q_pt.size() != 0), 1024'(1));
         if (q_pt.size() != 0) check_val("pt_out", 1024'(t_if.m_axis_tdata), q_pt.pop_front());
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1);
   end

   initial begin
      logic seen;
      aresetn  = 1'b0;
      sysref   = 1'b0;
      align_en = 1'b1;
      ovf_clr  = 1'b0;
      p_if.s_axis_tdata = '0; p_if.s_axis_tvalid = 1'b0; p_if.m_axis_tready = 1'b1;
      a_if.s_axis_tdata = '0; a_if.s_axis_tvalid = 1'b0; a_if.m_axis_tready = 1'b1;
      t_if.s_axis_tdata = '0; t_if.s_axis_tvalid = 1'b0; t_if.m_axis_tready = 1'b1;

      // Reset state
      #12;
      check_val("rst_pk_valid", 1024'(p_if.m_axis_tvalid), 1024'(0));
      check_val("rst_pk_data", 1024'(p_if.m_axis_tdata), 1024'(0));
      check_val("rst_pk_aligned", 1024'(pk_aligned), 1024'(1));
      check_val("rst_al_aligned", 1024'(al_aligned), 1024'(0));
      check_val("rst_al_ovf", 1024'(al_overflow), 1024'(0));
      check_val("rst_al_realign", 1024'(al_realign), 1024'(0));
      check_val("rst_pt_valid", 1024'(t_if.m_axis_tvalid), 1024'(0));
      @(posedge aclk); #1;
      aresetn = 1'b1;
      @(posedge aclk); #1;

      // Packing, RATIO=2
      pk_drive(8'hA0);
      check_val("pk_early", 1024'(p_if.m_axis_tvalid), 1024'(0));
      q_pk.push_back(grp(8'hA0, 2, 16));
      pk_drive(8'hA1);
      p_if.s_axis_tvalid = 1'b0;
      check_val("pk_latency", 1024'(p_if.m_axis_tvalid), 1024'(1));
      @(posedge aclk); #1;
      check_val("pk_drained", 1024'(p_if.m_axis_tvalid), 1024'(0));

      // Backpressure
      p_if.m_axis_tready = 1'b0;
      q_pk.push_back(grp(8'hC0, 2, 16));
      pk_drive(8'hC0);
      pk_drive(8'hC1);
      q_pk.push_back(grp(8'hD0, 2, 16));
      pk_drive(8'hD0);
      p_if.s_axis_tdata  = beat(8'hD1, 16);
      p_if.s_axis_tvalid = 1'b1;
      @(negedge aclk);
      check_val("bp_stall", 1024'(p_if.s_axis_tready), 1024'(0));
      @(posedge aclk); #1;
      check_val("bp_ovf_set", 1024'(pk_overflow), 1024'(1));
      check_val("bp_still_stalled", 1024'(p_if.s_axis_tready), 1024'(0));
      @(posedge aclk); #1;
      p_if.m_axis_tready = 1'b1;
      @(negedge aclk);
      check_val("bp_release_ready", 1024'(p_if.s_axis_tready), 1024'(1));
      @(posedge aclk); #1;
      p_if.s_axis_tvalid = 1'b0;
      check_val("bp_g2_valid", 1024'(p_if.m_axis_tvalid), 1024'(1));
      @(posedge aclk); #1;
      check_val("bp_ovf_sticky", 1024'(pk_overflow), 1024'(1));
      ovf_clr = 1'b1;
      @(posedge aclk); #1;
      ovf_clr = 1'b0;
      check_val("bp_ovf_clr", 1024'(pk_overflow), 1024'(0));
      check_val("pk_sb_drained", 1024'(q_pk.size()), 1024'(0));

      // Alignment, RATIO=4
      for (int v = 1; v <= 5; v++) begin
         al_drive(v, 1'b0);
         check_val("al_pre_valid", 1024'(a_if.m_axis_tvalid), 1024'(0));
      end
      check_val("al_pre_aligned", 1024'(al_aligned), 1024'(0));
      q_al.push_back(grp(8'h10, 4, 256));
      al_drive(8'h10, 1'b1);
      check_val("al_rise", 1024'(al_aligned), 1024'(1));
      al_drive(8'h11, 1'b0);
      al_drive(8'h12, 1'b0);
      al_drive(8'h13, 1'b0);
      a_if.s_axis_tvalid = 1'b0;
      check_val("al_latency", 1024'(a_if.m_axis_tvalid), 1024'(1));
      @(posedge aclk); #1;

      // Phase slip at phase 2, then an edge at phase 0
      al_drive(8'h20, 1'b0);
      al_drive(8'h21, 1'b0);
      q_al.push_back(grp(8'h30, 4, 256));
      al_drive(8'h30, 1'b1);
      check_val("slip_count", 1024'(al_realign), 1024'(1));
      al_drive(8'h31, 1'b0);
      al_drive(8'h32, 1'b0);
      al_drive(8'h33, 1'b0);
      q_al.push_back(grp(8'h40, 4, 256));
      al_drive(8'h40, 1'b1);
      al_drive(8'h41, 1'b0);
      al_drive(8'h42, 1'b0);
      al_drive(8'h43, 1'b0);
      a_if.s_axis_tvalid = 1'b0;
      check_val("slip_phase0", 1024'(al_realign), 1024'(1));
      repeat (3) @(posedge aclk);
      #1;
      check_val("al_sb_drained", 1024'(q_al.size()), 1024'(0));

      // Reset mid-group with a held output and a stall pending
      a_if.m_axis_tready = 1'b0;
      for (int v = 8'h60; v <= 8'h66; v++) al_drive(v, 1'b0);
      a_if.s_axis_tdata  = beat(8'h67, 256);
      a_if.s_axis_tvalid = 1'b1;
      @(posedge aclk); #1;
      check_val("rst_pre_ovf", 1024'(al_overflow), 1024'(1));
      check_val("rst_pre_valid", 1024'(a_if.m_axis_tvalid), 1024'(1));
      #2;
      aresetn = 1'b0;
      #1;
      check_val("rst_mid_valid", 1024'(a_if.m_axis_tvalid), 1024'(0));
      check_val("rst_mid_aligned", 1024'(al_aligned), 1024'(0));
      check_val("rst_mid_ovf", 1024'(al_overflow), 1024'(0));
      check_val("rst_mid_realign", 1024'(al_realign), 1024'(0));
      check_val("rst_mid_data", 1024'(a_if.m_axis_tdata), 1024'(0));
      a_if.s_axis_tvalid = 1'b0;
      a_if.m_axis_tready = 1'b1;
      @(posedge aclk); #1;
      aresetn = 1'b1;
      seen = 1'b0;
      for (int v = 8'h70; v < 8'h78; v++) begin
         al_drive(v, 1'b0);
         seen = seen | a_if.m_axis_tvalid;
      end
      a_if.s_axis_tvalid = 1'b0;
      check_val("rst_no_out", 1024'(seen), 1024'(0));
      check_val("rst_stay_unaligned", 1024'(al_aligned), 1024'(0));

      // RATIO=1 pass-through at full rate
      for (int i = 0; i < 4; i++) begin
         q_pt.push_back(grp(5 + i, 1, 0));
         t_if.s_axis_tdata  = beat(5 + i, 0);
         t_if.s_axis_tvalid = 1'b1;
         @(negedge aclk);
         check_val("pt_ready", 1024'(t_if.s_axis_tready), 1024'(1));
         if (i > 0) check_val("pt_rate", 1024'(t_if.m_axis_tvalid), 1024'(1));
         @(posedge aclk); #1;
      end
      t_if.s_axis_tvalid = 1'b0;
      check_val("pt_last", 1024'(t_if.m_axis_tvalid), 1024'(1));
      @(posedge aclk); #1;
      check_val("pt_idle", 1024'(t_if.m_axis_tvalid), 1024'(0));
      check_val("pt_sb_drained", 1024'(q_pt.size()), 1024'(0));

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
